paddle_pos_decoder: RTL and testbench
=====================================

PADDLE_POS_DECODER -- requirements
Module: paddle_pos_decoder

Interface
REQ-001 The block SHALL have parameter PTO, default 128, the number of clock cycles per count step minus one (8-bit value).
REQ-002 The block SHALL have parameter POSINI, default 150, the reset value of the position.
REQ-003 The block SHALL have parameter FLDTOP, default 42, the lower clamp bound of the position.
REQ-004 The block SHALL have parameter FLDBOT, default 210, the upper clamp bound of the position.
REQ-005 The block SHALL have parameter DEADBAND, default 2, the minimum position change, exclusive, that produces a direction strobe.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port i_padDWN, input, 1 bit: vertical-sync discharge; high means the sense capacitor is held discharged.
REQ-009 The block SHALL have port i_padCTRL, input, 1 bit: paddle sense line; it rises once per frame when the charge threshold is reached.
REQ-010 The block SHALL have port o_padPos, output, 8 bits: the last decoded and clamped paddle position.
REQ-011 The block SHALL have port o_valid, output, 1 bit: a one-cycle strobe indicating that o_padPos has just been updated.
REQ-012 The block SHALL have port o_timeout, output, 1 bit: a one-cycle strobe indicating that the frame ended without a sense edge.
REQ-013 The block SHALL have port o_up, output, 1 bit: a one-cycle strobe indicating that the position decreased by more than DEADBAND.
REQ-014 The block SHALL have port o_down, output, 1 bit: a one-cycle strobe indicating that the position increased by more than DEADBAND.
REQ-015 All inputs SHALL be synchronous to clock; the block SHALL include no input synchronisers.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE (discharging), COUNT (measuring) and DONE (waiting for the next frame).
REQ-017 In IDLE, the cycle counter cont1 and the step counter contN SHALL be held at 0, and the FSM SHALL move to COUNT on the first cycle in which i_padDWN is sampled low.
REQ-018 In COUNT, cont1 SHALL count 0..PTO and wrap to 0; contN SHALL increment by 1 on each cycle where cont1==PTO, so that step k begins (PTO+1)*k cycles after entering COUNT.
REQ-019 In COUNT, when i_padCTRL is sampled high, the current contN SHALL be captured as raw and the FSM SHALL move to DONE; this includes the first COUNT cycle, which gives raw=0.
REQ-020 In COUNT, when contN==255 and cont1==PTO without a sense edge, the FSM SHALL pulse o_timeout, leave o_padPos unchanged, and move to DONE; contN SHALL never wrap.
REQ-021 In COUNT, when i_padDWN is sampled high, the frame SHALL be aborted: o_timeout pulses, o_padPos is unchanged, and the FSM moves to IDLE; this case SHALL take priority over a simultaneous sense edge.
REQ-022 In DONE, further i_padCTRL activity SHALL be ignored, and the FSM SHALL move to IDLE when i_padDWN is sampled high.
REQ-023 The clamp SHALL compute pos = FLDTOP if raw < FLDTOP, FLDBOT if raw > FLDBOT, and raw otherwise, using unsigned 8-bit compares.
REQ-024 o_padPos SHALL be updated to pos, and o_valid SHALL pulse, exactly one cycle after the capture cycle.
REQ-025 Direction detection SHALL use 9-bit signed differences against the previous o_padPos.
REQ-026 o_up SHALL pulse in the same cycle as o_valid when (old - pos) > DEADBAND.
REQ-027 o_down SHALL pulse in the same cycle as o_valid when (pos - old) > DEADBAND.
REQ-028 o_up and o_down SHALL never both be high.
REQ-029 o_valid and o_timeout SHALL be mutually exclusive, and at most one of them SHALL pulse per frame.

Reset
REQ-030 While reset is high, the state SHALL be IDLE, cont1=0, contN=0, o_padPos=POSINI, and o_valid, o_timeout, o_up and o_down SHALL all be 0.
REQ-031 A reset asserted mid-COUNT SHALL discard the measurement; no strobe SHALL be produced for that frame.
REQ-032 After reset is released, the first measurement SHALL begin only at the next i_padDWN low.

Verification
REQ-033 Scenario: reset, i_padDWN falls, i_padCTRL rises 100*129 cycles later (contN=100) -> one cycle later o_padPos=100, o_valid=1, o_up=1 (150 to 100), o_down=0.
REQ-034 Scenario: sense rises at contN=20 -> o_padPos=42 (clamped); sense rises at contN=230 in the next frame -> o_padPos=210 with o_down=1.
REQ-035 Scenario: i_padCTRL held high before i_padDWN falls -> raw=0, o_padPos=42, o_valid=1.
REQ-036 Scenario: i_padCTRL never rises -> o_timeout pulses 256*129 cycles after COUNT entry, o_padPos is unchanged, and o_valid=0.
REQ-037 Scenario: previous position 100, sense rises at contN=102 -> o_padPos=102, o_valid=1, o_up=0, o_down=0 (within deadband).
REQ-038 Scenario: reset pulsed at contN=50 mid-COUNT -> no strobe, o_padPos=150; i_padDWN rising mid-COUNT -> o_timeout=1 and the FSM is in IDLE.

Source files
------------

// File: rtl/paddle_pos_decoder.sv
// Paddle position decoder: times the sense-line charge after vertical-sync discharge,
// clamps the step count to the playfield and emits position / direction strobes.
module paddle_pos_decoder #(
  parameter int unsigned PTO      = 128,
  parameter int unsigned POSINI   = 150,
  parameter int unsigned FLDTOP   = 42,
  parameter int unsigned FLDBOT   = 210,
  parameter int unsigned DEADBAND = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_padDWN,
  input  logic       i_padCTRL,
  output logic [7:0] o_padPos,
  output logic       o_valid,
  output logic       o_timeout,
  output logic       o_up,
  output logic       o_down
);

  localparam logic [7:0] PTO_V    = 8'(PTO);
  localparam logic [7:0] POSINI_V = 8'(POSINI);
  localparam logic [7:0] FLDTOP_V = 8'(FLDTOP);
  localparam logic [7:0] FLDBOT_V = 8'(FLDBOT);
  localparam logic signed [8:0] DEADBAND_V = 9'(DEADBAND);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cont1, cont1_nxt;
  logic [7:0] contN, contN_nxt;
  logic       capture;
  logic       tmo;

  logic [7:0]        raw;
  logic [7:0]        pos;
  logic signed [8:0] diff_up;
  logic signed [8:0] diff_down;
  logic              up_hit;
  logic              down_hit;

  // Abort on discharge outranks a sense edge in the same cycle.
  always_comb begin
    state_nxt = state;
    cont1_nxt = cont1;
    contN_nxt = contN;
    capture   = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        cont1_nxt = '0;
        contN_nxt = '0;
        if (!i_padDWN) state_nxt = COUNT;
      end
      COUNT: begin
        if (i_padDWN) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
          cont1_nxt = '0;
          contN_nxt = '0;
        end else if (i_padCTRL) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (cont1 == PTO_V) begin
          cont1_nxt = '0;
          if (contN == 8'hFF) begin
            tmo       = 1'b1;
            state_nxt = DONE;
          end else begin
            contN_nxt = contN + 8'd1;
          end
        end else begin
          cont1_nxt = cont1 + 8'd1;
        end
      end
      DONE: begin
        cont1_nxt = '0;
        contN_nxt = '0;
        if (i_padDWN) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cont1_nxt = '0;
        contN_nxt = '0;
      end
    endcase
  end

  always_comb begin
    raw = contN;
    if (raw < FLDTOP_V)      pos = FLDTOP_V;
    else if (raw > FLDBOT_V) pos = FLDBOT_V;
    else                     pos = raw;
    diff_up   = $signed({1'b0, o_padPos}) - $signed({1'b0, pos});
    diff_down = $signed({1'b0, pos}) - $signed({1'b0, o_padPos});
    up_hit    = diff_up > DEADBAND_V;
    down_hit  = diff_down > DEADBAND_V;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cont1     <= '0;
      contN     <= '0;
      o_padPos  <= POSINI_V;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      o_up      <= 1'b0;
      o_down    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cont1     <= cont1_nxt;
      contN     <= contN_nxt;
      o_valid   <= capture;
      o_timeout <= tmo;
      o_up      <= capture & up_hit;
      o_down    <= capture & down_hit;
      if (capture) o_padPos <= pos;
    end
  end

endmodule

// File: tb/tb_paddle_pos_decoder.sv
// Scoreboard bench for paddle_pos_decoder: directed frames push expected strobes,
// a negedge monitor pops and compares whenever o_valid or o_timeout fires.
module tb_paddle_pos_decoder;

  localparam int TB_PTO = 15;
  localparam int STEP   = TB_PTO + 1;
  localparam int OFF    = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       i_padDWN;
  logic       i_padCTRL;
  logic [7:0] o_padPos;
  logic       o_valid;
  logic       o_timeout;
  logic       o_up;
  logic       o_down;

  typedef struct {
    bit         tmo;
    logic [7:0] pos;
    bit         up;
    bit         down;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  paddle_pos_decoder #(
    .PTO(TB_PTO),
    .POSINI(150),
    .FLDTOP(42),
    .FLDBOT(210),
    .DEADBAND(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_padDWN(i_padDWN),
    .i_padCTRL(i_padCTRL),
    .o_padPos(o_padPos),
    .o_valid(o_valid),
    .o_timeout(o_timeout),
    .o_up(o_up),
    .o_down(o_down)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (reset === 1'b0 && (o_valid === 1'b1 || o_timeout === 1'b1)) begin
      exp_t e;
      chk("valid_timeout_exclusive", 32'(o_valid & o_timeout), 0);
      chk("up_down_exclusive", 32'(o_up & o_down), 0);
      if (q.size() == 0) begin
        chk("unexpected_strobe", 32'({o_valid, o_timeout}), 0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind_timeout", 32'(o_timeout), 32'(e.tmo));
        chk("strobe_kind_valid", 32'(o_valid), 32'(!e.tmo));
        chk("pad_pos", 32'(o_padPos), 32'(e.pos));
        chk("up", 32'(o_up), 32'(e.up));
        chk("down", 32'(o_down), 32'(e.down));
        if (e.cyc >= 0) chk("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input bit tmo, input logic [7:0] pos, input bit up, input bit down,
                      input int when);
    exp_t e;
    e.tmo = tmo; e.pos = pos; e.up = up; e.down = down; e.cyc = when;
    q.push_back(e);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q.size() > 0; i++) @(negedge clock);
    tick(1);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d strobes outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic idle_gap;
    i_padDWN  = 1'b1;
    i_padCTRL = 1'b0;
    tick(3);
  endtask

  // Sense edge sampled mid-step k; ctrl stays high in DONE to show it is ignored.
  task automatic frame(input int k, input logic [7:0] pos, input bit up, input bit down);
    int t;
    t = k * STEP + OFF;
    i_padDWN = 1'b0;
    tick(1 + t);
    i_padCTRL = 1'b1;
    push(1'b0, pos, up, down, cyc + 1);
    tick(6);
    drain(20);
    idle_gap();
  endtask

  initial begin
    reset     = 1'b1;
    i_padDWN  = 1'b1;
    i_padCTRL = 1'b0;
    tick(4);
    chk("reset_pos", 32'(o_padPos), 150);
    chk("reset_valid", 32'(o_valid), 0);
    chk("reset_timeout", 32'(o_timeout), 0);
    chk("reset_up", 32'(o_up), 0);
    chk("reset_down", 32'(o_down), 0);
    reset = 1'b0;
    tick(3);

    frame(100, 8'd100, 1, 0);
    frame(102, 8'd102, 0, 0);
    frame(20,  8'd42,  1, 0);
    frame(230, 8'd210, 0, 1);

    // Sense already high when discharge ends: raw 0 in the first COUNT cycle.
    i_padCTRL = 1'b1;
    tick(2);
    i_padDWN = 1'b0;
    push(1'b0, 8'd42, 1, 0, cyc + 2);
    tick(4);
    drain(20);
    idle_gap();

    frame(44,  8'd44,  0, 0);
    frame(47,  8'd47,  0, 1);
    frame(44,  8'd44,  1, 0);
    frame(42,  8'd42,  0, 0);
    frame(210, 8'd210, 0, 1);
    frame(211, 8'd210, 0, 0);
    frame(255, 8'd210, 0, 0);

    // No sense edge: timeout after 256 full steps, late sense in DONE ignored.
    i_padDWN = 1'b0;
    push(1'b1, 8'd210, 0, 0, cyc + 1 + 256 * STEP);
    drain(256 * STEP + 50);
    i_padCTRL = 1'b1;
    tick(8);
    idle_gap();

    // Discharge mid-COUNT with a simultaneous sense edge aborts the frame.
    i_padDWN = 1'b0;
    tick(20);
    i_padDWN  = 1'b1;
    i_padCTRL = 1'b1;
    push(1'b1, 8'd210, 0, 0, cyc + 1);
    tick(4);
    drain(20);
    idle_gap();

    // Reset mid-COUNT discards the frame.
    i_padDWN = 1'b0;
    tick(1 + 50 * STEP + OFF);
    reset    = 1'b1;
    i_padDWN = 1'b1;
    tick(2);
    chk("midreset_pos", 32'(o_padPos), 150);
    chk("midreset_strobes", 32'({o_valid, o_timeout, o_up, o_down}), 0);
    reset = 1'b0;
    tick(10);
    chk("post_reset_pos", 32'(o_padPos), 150);

    frame(100, 8'd100, 1, 0);

    tick(10);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
